jtgng_objdma: RTL and testbench

//  Bus-mastering copier that sits directly upstream of the object buffer jtgng_ram.
//  On a CPU trigger it requests the bus and copies LEN words from the CPU-side

---
 rtl/jtgng_objdma.sv | 109 ++++++++++
 tb/tb_jtgng_objdma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_objdma.sv
// Bus-mastering copier: on dma_start, acquires the bus and copies LEN words from the
// source RAM into the object RAM, one word per cen cycle, with resume on bus loss.
module jtgng_objdma #(
  parameter int AW  = 9,
  parameter int DW  = 8,
  parameter int LEN = 384
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_start,
  input  logic          bus_ack,
  output logic          bus_req,
  output logic          busy,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          dst_we,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, REQ, PRIME, COPY, DONE} state_t;

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

  state_t      state;
  logic [AW:0] rd_idx;
  logic [AW:0] wr_idx;
  logic [AW:0] wr_nxt;
  logic [AW:0] rd_nxt;

  assign wr_nxt = wr_idx + ONE;
  assign rd_nxt = rd_idx + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      busy     <= 1'b0;
      dst_we   <= 1'b0;
      done     <= 1'b0;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (cen) begin
        case (state)
          IDLE: begin
            if (dma_start) begin
              state   <= REQ;
              busy    <= 1'b1;
              bus_req <= 1'b1;
              rd_idx  <= '0;
              wr_idx  <= '0;
            end
          end
          REQ: begin
            dst_we <= 1'b0;
            if (bus_ack) begin
              state    <= PRIME;
              src_addr <= wr_idx[AW-1:0];
            end
          end
          PRIME: begin
            if (!bus_ack) begin
              state  <= REQ;
              dst_we <= 1'b0;
            end else begin
              state    <= COPY;
              rd_idx   <= wr_nxt;
              src_addr <= (wr_nxt > LAST) ? LAST[AW-1:0] : wr_nxt[AW-1:0];
            end
          end
          COPY: begin
            if (!bus_ack) begin
              state  <= REQ;
              dst_we <= 1'b0;
            end else begin
              dst_addr <= wr_idx[AW-1:0];
              dst_data <= src_data;
              dst_we   <= 1'b1;
              wr_idx   <= wr_nxt;
              // rd_idx is the address currently on src_addr; advance but never past LAST
              if (rd_idx < LAST) begin
                rd_idx   <= rd_nxt;
                src_addr <= rd_nxt[AW-1:0];
              end
              if (wr_idx == LAST) state <= DONE;
            end
          end
          DONE: begin
            dst_we  <= 1'b0;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtgng_objdma.sv
// Bench for jtgng_objdma: three instances (LEN 4, 384, 1) fed by behavioural RAM models,
// checked against transfer-level expectations derived from the copy rules.
module tb_jtgng_objdma;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int LENS [NI] = '{4, 384, 1};

  logic          clk = 1'b0;
  logic          cen = 1'b0;
  logic          rst_n    [NI];
  logic          start    [NI];
  logic          ack      [NI];
  logic          bus_req  [NI];
  logic          busy     [NI];
  logic [AW-1:0] src_addr [NI];
  logic [DW-1:0] src_data [NI];
  logic [AW-1:0] dst_addr [NI];
  logic [DW-1:0] dst_data [NI];
  logic          dst_we   [NI];
  logic          done     [NI];

  always #5 clk = ~clk;

  jtgng_objdma #(.AW(AW), .DW(DW), .LEN(4)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .cen(cen), .dma_start(start[0]), .bus_ack(ack[0]),
    .bus_req(bus_req[0]), .busy(busy[0]), .src_addr(src_addr[0]), .src_data(src_data[0]),
    .dst_addr(dst_addr[0]), .dst_data(dst_data[0]), .dst_we(dst_we[0]), .done(done[0]));
  jtgng_objdma #(.AW(AW), .DW(DW), .LEN(384)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .cen(cen), .dma_start(start[1]), .bus_ack(ack[1]),
    .bus_req(bus_req[1]), .busy(busy[1]), .src_addr(src_addr[1]), .src_data(src_data[1]),
    .dst_addr(dst_addr[1]), .dst_data(dst_data[1]), .dst_we(dst_we[1]), .done(done[1]));
  jtgng_objdma #(.AW(AW), .DW(DW), .LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .cen(cen), .dma_start(start[2]), .bus_ack(ack[2]),
    .bus_req(bus_req[2]), .busy(busy[2]), .src_addr(src_addr[2]), .src_data(src_data[2]),
    .dst_addr(dst_addr[2]), .dst_data(dst_data[2]), .dst_we(dst_we[2]), .done(done[2]));

  // Memory models and event counters; only this block writes them
  logic [DW-1:0] src_mem [NI][512];
  logic [DW-1:0] dst_mem [NI][512];
  int wflag [NI][512];
  int wcnt [NI] = '{0, 0, 0};
  int dups [NI] = '{0, 0, 0};
  int done_cnt [NI] = '{0, 0, 0};
  int overlap [NI] = '{0, 0, 0};
  int busy_edges [NI] = '{0, 0, 0};
  int last_wr_clk [NI] = '{0, 0, 0};
  int done_clk [NI] = '{0, 0, 0};
  int cyc = 0;
  int epoch = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (cen) src_data[k] <= src_mem[k][src_addr[k]];
      if (cen && dst_we[k]) begin
        if (wflag[k][dst_addr[k]] == epoch) dups[k] = dups[k] + 1;
        wflag[k][dst_addr[k]] = epoch;
        dst_mem[k][dst_addr[k]] = dst_data[k];
        wcnt[k] = wcnt[k] + 1;
        last_wr_clk[k] = cyc;
      end
      if (done[k]) begin
        done_cnt[k] = done_cnt[k] + 1;
        done_clk[k] = cyc;
      end
      if (done[k] && busy[k]) overlap[k] = overlap[k] + 1;
      if (cen && busy[k]) busy_edges[k] = busy_edges[k] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int sel;
    int div;
    int ack_delay;
    int drop_at;
    int drop_len;
    int restart_at;
    int exp_writes;
    int exp_busy;
  } vec_t;

  function automatic vec_t mk(input int sel, input int div, input int ad,
                              input int drop_at, input int drop_len, input int rs);
    vec_t v;
    v.sel = sel; v.div = div; v.ack_delay = ad;
    v.drop_at = drop_at; v.drop_len = drop_len; v.restart_at = rs;
    v.exp_writes = LENS[sel];
    // REQ (delay + ack cycle), PRIME, LEN COPY cycles, DONE; a bus loss costs its
    // low cycles plus a fresh REQ and PRIME
    v.exp_busy = ad + LENS[sel] + 3 + ((drop_at >= 0) ? drop_len + 2 : 0);
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int s;
    int n;
    int w0, d0, dn0, b0, ov0;
    int ph, low_left, cyc_n, post, bad;
    bit issued, dropped, restarted, fin;
    s = v.sel; n = LENS[s];
    ph = 0; cyc_n = 0; post = 0; bad = 0;
    issued = 0; dropped = 0; restarted = 0; fin = 0;
    epoch = epoch + 1;
    for (int i = 0; i < n; i++) src_mem[s][i] = 8'($urandom);
    @(negedge clk);
    w0 = wcnt[s]; d0 = dups[s]; dn0 = done_cnt[s]; b0 = busy_edges[s]; ov0 = overlap[s];
    low_left = v.ack_delay;
    ack[s] = (v.ack_delay == 0);
    while (!fin && cyc_n < 20000) begin
      bit ps;
      bit c;
      ps = issued;
      c = (ph % v.div) == 0;
      ph = ph + 1;
      cen = c;
      if (v.drop_at >= 0 && !dropped && (wcnt[s] - w0) >= v.drop_at + 1) begin
        low_left = v.drop_len;
        dropped = 1;
      end
      if (ps && c) begin
        ack[s] = (low_left == 0);
        if (low_left > 0) low_left = low_left - 1;
      end
      start[s] = 1'b0;
      if (!issued && c) begin
        start[s] = 1'b1;
        issued = 1;
      end else if (v.restart_at >= 0 && !restarted && c && (wcnt[s] - w0) >= v.restart_at) begin
        start[s] = 1'b1;
        restarted = 1;
      end
      @(negedge clk);
      cyc_n = cyc_n + 1;
      if (done_cnt[s] != dn0 && post == 0) post = 1;
      if (post > 0) begin
        post = post + 1;
        if (post > 12) fin = 1;
      end
    end
    start[s] = 1'b0; ack[s] = 1'b1; cen = 1'b1;
    if (!fin) check({tag, "_timeout"}, 0, 1);
    for (int i = 0; i < n; i++)
      if (wflag[s][i] != epoch || dst_mem[s][i] != src_mem[s][i]) bad = bad + 1;
    check({tag, "_writes"}, wcnt[s] - w0, v.exp_writes);
    check({tag, "_dups"}, dups[s] - d0, 0);
    check({tag, "_data_bad"}, bad, 0);
    check({tag, "_done_pulses"}, done_cnt[s] - dn0, 1);
    check({tag, "_busy_cens"}, busy_edges[s] - b0, v.exp_busy);
    check({tag, "_done_after_last_wr"}, done_clk[s] - last_wr_clk[s], 1);
    check({tag, "_done_busy_overlap"}, overlap[s] - ov0, 0);
    check({tag, "_idle_outputs"}, {30'd0, bus_req[s], busy[s]}, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int w0, dn0, k;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; ack[i] = 1'b1;
      for (int j = 0; j < 512; j++) begin
        src_mem[i][j] = '0;
        dst_mem[i][j] = '0;
      end
    end

    vecs.push_back(mk(0, 1, 0, -1, 0, -1));        // LEN=4 back-to-back
    vecs.push_back(mk(1, 3, 0, -1, 0, -1));        // cen every 3rd clk
    vecs.push_back(mk(1, 1, 0, 10, 5, -1));        // bus loss after word 10
    vecs.push_back(mk(1, 2, 0, -1, 0, 50));        // restart mid-copy ignored
    vecs.push_back(mk(2, 1, 7, -1, 0, -1));        // LEN=1, late grant
    vecs.push_back(mk(2, 3, 0, -1, 0, -1));
    vecs.push_back(mk(0, int'($urandom_range(1, 4)), int'($urandom_range(0, 5)), -1, 0, -1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, int'($urandom_range(1, 3)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 381)), int'($urandom_range(1, 9)),
                        int'($urandom_range(0, 383))));

    // Reset asserted with cen low must still clear every output
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_outputs_%0d", i),
            {bus_req[i], busy[i], dst_we[i], done[i], src_addr[i], dst_addr[i], dst_data[i]}, 0);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    cen = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Abort by reset near word 100, then a clean full copy
    epoch = epoch + 1;
    for (int i = 0; i < LENS[1]; i++) src_mem[1][i] = 8'($urandom);
    cen = 1'b1; ack[1] = 1'b1;
    w0 = wcnt[1]; dn0 = done_cnt[1];
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    k = 0;
    while ((wcnt[1] - w0) < 100 && k < 2000) begin
      @(negedge clk);
      k = k + 1;
    end
    check("abort_reached_word100", int'((wcnt[1] - w0) >= 100), 1);
    rst_n[1] = 1'b0;
    @(negedge clk);
    check("abort_outputs", {29'd0, dst_we[1], bus_req[1], busy[1]}, 0);
    rst_n[1] = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt[1] - dn0, 0);
    check("abort_stays_idle", {30'd0, busy[1], bus_req[1]}, 0);
    run_vec("after_abort", mk(1, 1, 0, -1, 0, -1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
